// File: rtl/irq_arbiter_ctrl.sv
// Interrupt arbiter: masks level requests from N_SRC peripherals, serves the
// lowest pending index to the CPU, and returns a one-cycle acknowledge pulse
// to the serviced peripheral once the CPU signals return-from-interrupt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for GEN[0]=1 and a non-zero PENDING; latches the id
// SERVE   | irq_o high for the latched id until irq_ret_i
// RETURN  | one-cycle src_ret_o pulse to the latched id, then IDLE
module irq_arbiter_ctrl #(
  parameter int N_SRC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  input  logic [N_SRC-1:0]  src_irq_i,
  output logic [N_SRC-1:0]  src_ret_o,
  output logic              irq_o,
  output logic [4:0]        irq_id_o,
  input  logic              irq_ret_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SERVE  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  localparam logic [31:0] ADDR_MASK    = 32'h0000_0000;
  localparam logic [31:0] ADDR_PENDING = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0008;
  localparam logic [31:0] ADDR_GEN     = 32'h0000_000C;
  localparam logic [31:0] RD_UNMAPPED  = 32'hdead_beef;

  logic [1:0]       state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             gen_q, gen_d;
  logic [4:0]       irq_id_q, irq_id_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_SRC-1:0] pending;
  logic [31:0]      mask_ext;
  logic [31:0]      pending_ext;
  logic [31:0]      status;
  logic [4:0]       first_id;
  logic             busy;
  logic             bus_wr;
  logic             bus_rd;
  logic             unused_wdata;

  // Only the low bits of write data reach a register; the rest are don't-care.
  assign unused_wdata = ^write_data_i;

  assign bus_wr  = req_i & write_enable_i;
  assign bus_rd  = req_i & ~write_enable_i;
  assign pending = src_irq_i & mask_q;
  assign busy    = (state_q != ST_IDLE);
  assign status  = {26'd0, busy, irq_id_q};

  // Zero-extend mask/pending to the 32-bit bus view.
  always_comb begin
    mask_ext                 = '0;
    pending_ext              = '0;
    mask_ext[N_SRC-1:0]      = mask_q;
    pending_ext[N_SRC-1:0]   = pending;
  end

  // Fixed priority: lowest pending index wins (scan high to low, last hit kept).
  always_comb begin
    first_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i]) first_id = 5'(i);
    end
  end

  // Register file writes and registered read-back.
  always_comb begin
    mask_d  = mask_q;
    gen_d   = gen_q;
    rdata_d = rdata_q;
    if (bus_wr) begin
      case (addr_i)
        ADDR_MASK: mask_d = write_data_i[N_SRC-1:0];
        ADDR_GEN:  gen_d  = write_data_i[0];
        default:   ;
      endcase
    end
    if (bus_rd) begin
      case (addr_i)
        ADDR_MASK:    rdata_d = mask_ext;
        ADDR_PENDING: rdata_d = pending_ext;
        ADDR_STATUS:  rdata_d = status;
        ADDR_GEN:     rdata_d = {31'd0, gen_q};
        default:      rdata_d = RD_UNMAPPED;
      endcase
    end
  end

  // Arbitration FSM; IDLE samples the mask as it stood before any same-cycle write.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (gen_q && (pending != '0)) begin
          irq_id_d = first_id;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (irq_ret_i) state_d = ST_RETURN;
      end
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    irq_o     = (state_q == ST_SERVE);
    irq_id_o  = irq_o ? irq_id_q : 5'd0;
    src_ret_o = '0;
    if (state_q == ST_RETURN) src_ret_o = N_SRC'(1) << irq_id_q;
  end

  assign read_data_o = rdata_q;

  // State and configuration flops with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      gen_q    <= 1'b0;
      irq_id_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      gen_q    <= gen_d;
      irq_id_q <= irq_id_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
